// File: rtl/reg_pipe.sv
// reg_pipe: DEPTH-stage WIDTH-bit register pipeline with a per-stage valid/ready
// handshake, bubble collapsing and synchronous flush. Define REG_PIPE_OCCUPANCY_EN
// to add the registered occupancy output.
module reg_pipe #(
    parameter int              WIDTH     = 8,
    parameter int              DEPTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
`ifdef REG_PIPE_OCCUPANCY_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

    logic [DEPTH-1:0] v_q, v_d;
    logic [WIDTH-1:0] d_q [DEPTH];
    logic [WIDTH-1:0] d_d [DEPTH];

    // Upstream view of each stage: stage 0 is fed by the producer.
    logic [DEPTH-1:0] up_v;
    logic [WIDTH-1:0] up_d [DEPTH];
    logic [DEPTH:0]   rdy;

    // NOTE: every signal written here gets a default before any branch, so no latch is inferred.
    always_comb begin
        up_v[0] = in_valid;
        up_d[0] = in_data;
        for (int k = 1; k < DEPTH; k++) begin
            up_v[k] = v_q[k-1];
            up_d[k] = d_q[k-1];
        end

        // An empty stage is always ready, which is what squeezes bubbles out.
        rdy[DEPTH] = out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            rdy[k] = !v_q[k] || rdy[k+1];
        end
    end

    assign in_ready  = rdy[0] && !flush;
    assign out_valid = v_q[DEPTH-1];
    assign out_data  = d_q[DEPTH-1];

    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (flush) begin
            v_d = '0;
            for (int k = 0; k < DEPTH; k++) begin
                d_d[k] = RESET_VAL;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (rdy[k]) begin
                    v_d[k] = up_v[k];
                    if (up_v[k]) begin
                        d_d[k] = up_d[k];
                    end
                end
            end
        end
    end

    // NOTE: the data registers are reset too, because out_data must read RESET_VAL during reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                d_q[k] <= RESET_VAL;
            end
        end else begin
            // NOTE: non-blocking assignments so every stage samples the pre-edge value of its neighbour.
            v_q <= v_d;
            d_q <= d_d;
        end
    end

`ifdef REG_PIPE_OCCUPANCY_EN
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [OCC_W-1:0] occ_q, occ_d;
    logic             in_xfer, out_xfer;

    always_comb begin
        in_xfer  = in_valid && in_ready;
        out_xfer = out_valid && out_ready;
        occ_d    = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (in_xfer && !out_xfer) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (out_xfer && !in_xfer) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;
`endif

endmodule

// File: tb/tb_reg_pipe.sv
// Directed bench for reg_pipe (WIDTH=8, DEPTH=3, RESET_VAL=0) plus a modelled
// random phase; occupancy is checked when REG_PIPE_OCCUPANCY_EN is defined.
module tb_reg_pipe;
    localparam int WIDTH = 8;
    localparam int DEPTH = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_ready = 1'b0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
`ifdef REG_PIPE_OCCUPANCY_EN
    logic [1:0]       occupancy;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model state for the random phase.
    logic [DEPTH-1:0] mv;
    logic [WIDTH-1:0] md [DEPTH];
    logic [DEPTH:0]   mrdy;
    int               mocc;

    reg_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(8'h00)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
`ifdef REG_PIPE_OCCUPANCY_EN
        ,
        .occupancy (occupancy)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_occ(input string tag, input int exp_v);
`ifdef REG_PIPE_OCCUPANCY_EN
        check(tag, 32'(occupancy), 32'(exp_v));
`else
        if (exp_v < 0) $display("occupancy not built: %s", tag);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [WIDTH-1:0] d, input logic r, input logic f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        #1;
    endtask

    initial begin
        // Reset state.
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'h00);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check_occ("rst_occ", 0);
        @(negedge clk);
        reset = 1'b0;

        // Latency and streaming.
        set_in(1'b1, 8'h11, 1'b1, 1'b0);
        check("lat_in_ready0", 32'(in_ready), 32'd1);
        tick();
        check("lat_empty1", 32'(out_valid), 32'd0);
        set_in(1'b1, 8'h22, 1'b1, 1'b0);
        check("lat_in_ready1", 32'(in_ready), 32'd1);
        tick();
        check("lat_empty2", 32'(out_valid), 32'd0);
        set_in(1'b1, 8'h33, 1'b1, 1'b0);
        tick();
        check("lat_v11", 32'(out_valid), 32'd1);
        check("lat_d11", 32'(out_data), 32'h11);
        check_occ("lat_occ3", 3);
        set_in(1'b1, 8'h44, 1'b1, 1'b0);
        check("lat_in_ready_full", 32'(in_ready), 32'd1);
        tick();
        check("lat_d22", 32'(out_data), 32'h22);
        set_in(1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        check("lat_d33", 32'(out_data), 32'h33);
        tick();
        check("lat_d44", 32'(out_data), 32'h44);
        check("lat_v44", 32'(out_valid), 32'd1);
        tick();
        check("lat_drained", 32'(out_valid), 32'd0);
        check_occ("lat_occ0", 0);

        // Back-pressure fill.
        set_in(1'b1, 8'hA1, 1'b0, 1'b0);
        tick();
        set_in(1'b1, 8'hA2, 1'b0, 1'b0);
        check("bp_in_ready_a2", 32'(in_ready), 32'd1);
        tick();
        set_in(1'b1, 8'hA3, 1'b0, 1'b0);
        check("bp_in_ready_a3", 32'(in_ready), 32'd1);
        tick();
        check("bp_head_a1", 32'(out_data), 32'hA1);
        check_occ("bp_occ_full", 3);
        set_in(1'b1, 8'hA4, 1'b0, 1'b0);
        check("bp_in_ready_full", 32'(in_ready), 32'd0);
        tick();
        check("bp_stable_a1", 32'(out_data), 32'hA1);
        check("bp_stable_v", 32'(out_valid), 32'd1);
        check("bp_still_blocked", 32'(in_ready), 32'd0);
        set_in(1'b1, 8'hA4, 1'b1, 1'b0);
        check("bp_in_ready_flow", 32'(in_ready), 32'd1);
        tick();
        check("bp_out_a2", 32'(out_data), 32'hA2);
        set_in(1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        check("bp_out_a3", 32'(out_data), 32'hA3);
        tick();
        check("bp_out_a4", 32'(out_data), 32'hA4);
        check("bp_out_a4_v", 32'(out_valid), 32'd1);
        tick();
        check("bp_drained", 32'(out_valid), 32'd0);

        // Bubble collapse.
        set_in(1'b1, 8'h05, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        tick();
        check("bc_head_05", 32'(out_data), 32'h05);
        set_in(1'b1, 8'h06, 1'b0, 1'b0);
        check("bc_in_ready", 32'(in_ready), 32'd1);
        tick();
        set_in(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        check("bc_in_ready_gap", 32'(in_ready), 32'd1);
        check_occ("bc_occ2", 2);
        set_in(1'b0, 8'h00, 1'b1, 1'b0);
        check("bc_out_05", 32'(out_data), 32'h05);
        tick();
        check("bc_out_06_v", 32'(out_valid), 32'd1);
        check("bc_out_06", 32'(out_data), 32'h06);
        tick();
        check("bc_drained", 32'(out_valid), 32'd0);

        // Flush drops contents and refuses the word presented with it.
        set_in(1'b1, 8'hB1, 1'b0, 1'b0);
        tick();
        set_in(1'b1, 8'hB2, 1'b0, 1'b0);
        tick();
        set_in(1'b1, 8'hB3, 1'b0, 1'b1);
        check("fl_in_ready", 32'(in_ready), 32'd0);
        tick();
        set_in(1'b0, 8'h00, 1'b1, 1'b0);
        check("fl_out_valid", 32'(out_valid), 32'd0);
        check("fl_out_data", 32'(out_data), 32'h00);
        check_occ("fl_occ", 0);
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            check("fl_b3_dropped", 32'(out_valid), 32'd0);
        end

        // Reset mid-stream, asserted between edges.
        set_in(1'b1, 8'hC1, 1'b0, 1'b0);
        tick();
        set_in(1'b1, 8'hC2, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        check("mr_before", 32'(out_data), 32'hC1);
        #3;
        reset = 1'b1;
        #1;
        check("mr_out_valid", 32'(out_valid), 32'd0);
        check("mr_out_data", 32'(out_data), 32'h00);
        check("mr_in_ready", 32'(in_ready), 32'd1);
        check_occ("mr_occ", 0);
        @(negedge clk);
        reset = 1'b0;
        set_in(1'b1, 8'hD1, 1'b1, 1'b0);
        tick();
        set_in(1'b0, 8'h00, 1'b1, 1'b0);
        check("mr_lat1", 32'(out_valid), 32'd0);
        tick();
        check("mr_lat2", 32'(out_valid), 32'd0);
        tick();
        check("mr_lat3_v", 32'(out_valid), 32'd1);
        check("mr_lat3_d", 32'(out_data), 32'hD1);

        // Random traffic against a stage-level model, starting from a flushed pipe.
        set_in(1'b0, 8'h00, 1'b0, 1'b1);
        tick();
        mv = '0;
        for (int k = 0; k < DEPTH; k++) md[k] = 8'h00;
        for (int c = 0; c < 1000; c++) begin
            set_in(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 40) == 0));
            mrdy[DEPTH] = out_ready;
            for (int k = DEPTH - 1; k >= 0; k--) mrdy[k] = !mv[k] || mrdy[k+1];
            mocc = 0;
            for (int k = 0; k < DEPTH; k++) mocc += int'(mv[k]);
            check("rnd_in_ready", 32'(in_ready), 32'(mrdy[0] && !flush));
            check("rnd_out_valid", 32'(out_valid), 32'(mv[DEPTH-1]));
            check("rnd_out_data", 32'(out_data), 32'(md[DEPTH-1]));
            check_occ("rnd_occ", mocc);
            if (flush) begin
                mv = '0;
                for (int k = 0; k < DEPTH; k++) md[k] = 8'h00;
            end else begin
                for (int k = DEPTH - 1; k >= 0; k--) begin
                    if (mrdy[k]) begin
                        if (k == 0) begin
                            mv[0] = in_valid;
                            if (in_valid) md[0] = in_data;
                        end else begin
                            mv[k] = mv[k-1];
                            if (mv[k-1]) md[k] = md[k-1];
                        end
                    end
                end
            end
            tick();
        end

        // Occupancy returns to zero after flush and after reset.
        set_in(1'b0, 8'h00, 1'b0, 1'b1);
        tick();
        set_in(1'b0, 8'h00, 1'b0, 1'b0);
        check("end_flush_valid", 32'(out_valid), 32'd0);
        check_occ("end_flush_occ", 0);
        set_in(1'b1, 8'hE1, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 8'h00, 1'b0, 1'b0);
        check_occ("end_occ1", 1);
        reset = 1'b1;
        #1;
        check_occ("end_reset_occ", 0);
        check("end_reset_in_ready", 32'(in_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
